timer_arbiter: RTL and testbench

Shares one programmable countdown timer among NREQ requesters. Each requester asks for a timed OUT window of its own length, LEN. The block arbitrates, loads the shared counter and drives OUT for exactly LEN cycles. It then pulses a per-requester DONE. It sits in front of the timer datapath and optionally supports retrigger (MODE=1) and abort.

---
 rtl/timer_arbiter_if.sv | 26 ++
 rtl/timer_arbiter.sv | 156 +++++++++++++++
 tb/tb_timer_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_arbiter_if.sv
// rtl/timer_arbiter_if.sv - requester-side bundle for the shared countdown timer arbiter
interface timer_arbiter_if #(
    parameter int NREQ = 4,
    parameter int CW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    trg;
    logic               mode;
    logic [NREQ-1:0]    gnt;
    logic               out;
    logic [NREQ-1:0]    done;
    logic               busy;

    // requesters drive the request side and observe the timer status
    modport master (
        output req, len, trg, mode,
        input  gnt, out, done, busy
    );

    // the arbiter consumes requests and drives the timer status
    modport slave (
        input  req, len, trg, mode,
        output gnt, out, done, busy
    );
endinterface

// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - shared countdown timer with requester arbitration (TIMER_ARB_RR_EN selects round-robin)
module timer_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    timer_arbiter_if.slave  io_bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] C_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t          r_state;
    logic [NREQ-1:0] r_gnt;
    logic            r_out;
    logic [NREQ-1:0] r_done;
    logic            r_busy;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_idx;

    logic            w_any;
    logic [IW-1:0]   w_win;
    logic [NREQ-1:0] w_win_oh;
    logic [CW-1:0]   w_win_len;
    logic [CW-1:0]   w_cur_len;

`ifdef TIMER_ARB_RR_EN
    logic [IW-1:0]   r_ptr;
    int              w_j;

    // index that follows idx, wrapping at NREQ (pointer is not a power of two in general)
    function automatic logic [IW-1:0] f_next(input logic [IW-1:0] idx);
        if (int'(idx) == NREQ - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // round-robin winner: scan downward so the candidate nearest the pointer is written last
    always_comb begin
        w_win = '0;
        w_j   = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_j = int'(r_ptr) + i;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            if (io_bus.req[w_j]) begin
                w_win = w_j[IW-1:0];
            end
        end
    end
`else
    // fixed priority winner: scan downward so the lowest requesting index is written last
    always_comb begin
        w_win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (io_bus.req[i]) begin
                w_win = IW'(i);
            end
        end
    end
`endif

    assign w_any     = |io_bus.req;
    assign w_win_oh  = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
    assign w_win_len = io_bus.len[int'(w_win)*CW +: CW];
    assign w_cur_len = io_bus.len[int'(r_idx)*CW +: CW];

    // control FSM; every status output is a register so nothing is combinational from inputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_out   <= 1'b0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= '0;
`ifdef TIMER_ARB_RR_EN
            r_ptr   <= '0;
`endif
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_idx  <= w_win;
                        r_gnt  <= w_win_oh;
                        r_cnt  <= w_win_len;
                        r_busy <= 1'b1;
                        if (w_win_len != '0) begin
                            r_state <= S_RUN;
                            r_out   <= 1'b1;
                        end else begin
                            // zero-length window completes without ever raising OUT
                            r_state <= S_FIN;
                            r_done  <= w_win_oh;
                        end
                    end
                end
                S_RUN: begin
                    if (!io_bus.req[r_idx]) begin
                        // requester let go early: release silently
                        r_state <= S_IDLE;
                        r_gnt   <= '0;
                        r_out   <= 1'b0;
                        r_busy  <= 1'b0;
`ifdef TIMER_ARB_RR_EN
                        r_ptr   <= f_next(r_idx);
`endif
                    end else if (io_bus.mode && io_bus.trg[r_idx]) begin
                        // retrigger reloads the full length rather than extending it
                        r_cnt <= w_cur_len;
                        if (w_cur_len == '0) begin
                            r_state <= S_FIN;
                            r_out   <= 1'b0;
                            r_done  <= r_gnt;
                        end
                    end else if (r_cnt == C_ONE) begin
                        r_state <= S_FIN;
                        r_out   <= 1'b0;
                        r_done  <= r_gnt;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
`ifdef TIMER_ARB_RR_EN
                    r_ptr   <= f_next(r_idx);
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_out   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.gnt  = r_gnt;
    assign io_bus.out  = r_out;
    assign io_bus.done = r_done;
    assign io_bus.busy = r_busy;
endmodule

// File: tb/tb_timer_arbiter.sv
// tb/tb_timer_arbiter.sv - scoreboard bench for timer_arbiter with a window-level reference model
module tb_timer_arbiter;
    localparam int NREQ = 4;
    localparam int CW   = 8;

    typedef struct {
        int idx;
        int outc;
        int done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   m_ptr = 0;
    int   lens[NREQ];
    exp_t exp_q[$];

    timer_arbiter_if #(.NREQ(NREQ), .CW(CW)) bus ();

    timer_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // arbitration rule: who wins given a held request mask and the rotation start
    function automatic int pick(input int mask, input int ptr);
`ifdef TIMER_ARB_RR_EN
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
`else
        if (ptr < 0) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (mask[k]) return k;
        end
`endif
        return -1;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic set_len(input int i, input int v);
        bus.len[i*CW +: CW] = CW'(v);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"},  int'(bus.gnt), 0);
        check({tag, "_out"},  int'(bus.out), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    // monitor: measures each grant window and compares it with the next scoreboard entry
    initial begin
        logic [NREQ-1:0] prev_gnt;
        int cur_idx, cur_out, cur_done, cur_bad, idle_bad;
        exp_t e;
        prev_gnt = '0;
        cur_idx = 0; cur_out = 0; cur_done = 0; cur_bad = 0; idle_bad = 0;
        @(posedge rst_n);
        forever begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                if (prev_gnt == '0) begin
                    cur_idx = idx_of(bus.gnt);
                    cur_out = 0; cur_done = 0; cur_bad = 0;
                end
                if (bus.out) cur_out++;
                if (bus.done != '0) begin
                    cur_done++;
                    if (bus.done != bus.gnt) cur_bad = 1;
                end
                if (!bus.busy) cur_bad = 1;
                if ($countones(bus.gnt) != 1) cur_bad = 1;
            end else begin
                if (bus.out || bus.busy || (bus.done != '0)) idle_bad = 1;
                if (prev_gnt != '0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_grant: got idx %0d expected no grant", cur_idx);
                    end else begin
                        e = exp_q.pop_front();
                        check("gnt_idx", cur_idx, e.idx);
                        check("out_cycles", cur_out, e.outc);
                        check("done_pulses", cur_done, e.done);
                        check("window_integrity", cur_bad, 0);
                        check("idle_quiet", idle_bad, 0);
                        idle_bad = 0;
                    end
                end
            end
            prev_gnt = bus.gnt;
        end
    end

    // actions: 0 none (LEN changed mid-run), 1 retrigger with new LEN, 2 abort,
    // 3 reset mid-run, 4 TRG on another index, 5 TRG while MODE=0
    task automatic run_single(input int i, input int L, input int act, input int t, input int L2);
        exp_t e;
        int a;
        int g;
        a = act;
        if (L < 2) a = 0;
        e.idx = i; e.outc = L; e.done = 1;
        case (a)
            1:       e.outc = t + L2;
            2, 3:    begin e.outc = t; e.done = 0; end
            default: ;
        endcase
        exp_q.push_back(e);
        m_ptr = (a == 3) ? 0 : (i + 1) % NREQ;

        set_len(i, L);
        bus.mode = ($urandom_range(0, 1) == 1);
        bus.trg  = '0;
        bus.req  = NREQ'(1) << i;
        @(negedge clk);
        check("grant_latency", int'(bus.gnt), 1 << i);
        if (a != 0) repeat (t - 1) @(negedge clk);
        case (a)
            0: set_len(i, $urandom_range(0, 255));
            1: begin bus.mode = 1'b1; set_len(i, L2); bus.trg = NREQ'(1) << i; end
            2: bus.req = '0;
            3: rst_n = 1'b0;
            4: begin bus.mode = 1'b1; bus.trg = NREQ'(1) << ((i + 1) % NREQ); end
            5: begin bus.mode = 1'b0; bus.trg = NREQ'(1) << i; end
            default: ;
        endcase
        @(negedge clk);
        bus.trg = '0;
        if (a == 3) begin
            check_quiet("midrun_reset");
            rst_n = 1'b1;
        end
        if (a == 2) check("abort_gnt_next", int'(bus.gnt), 0);
        g = 0;
        while (bus.gnt != '0 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check("window_end_bound", int'(bus.gnt != '0), 0);
        bus.req = '0;
    endtask

    // all requesters in mask held until K completions; lens[] gives each window
    task automatic run_contention(input int mask, input int K);
        int wseq[$];
        int p, w, cnt, last, g;
        exp_t e;
        p = m_ptr;
        for (int n = 0; n < K; n++) begin
            w = pick(mask, p);
            wseq.push_back(w);
            e.idx = w; e.outc = lens[w]; e.done = 1;
            exp_q.push_back(e);
            p = (w + 1) % NREQ;
        end
        m_ptr = p;
        for (int n = 0; n < NREQ; n++) set_len(n, lens[n]);
        bus.mode = 1'b0;
        bus.trg  = '0;
        bus.req  = NREQ'(mask);
        cnt = 0; last = -1; g = 0;
        while (cnt < K && g < 3000) begin
            @(negedge clk);
            g++;
            if (bus.done != '0) begin
                if (last >= 0) check("done_gap", cyc - last, lens[wseq[cnt]] + 2);
                last = cyc;
                cnt++;
            end
        end
        check("contention_done_count", cnt, K);
        bus.req = '0;
        g = 0;
        while (bus.gnt != '0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("contention_end_bound", int'(bus.gnt != '0), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i, L, a, t, L2, mask, k;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.len  = '0;
        bus.trg  = '0;
        bus.mode = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_single(0, 5, 0, 1, 0);
        for (int n = 0; n < NREQ; n++) lens[n] = 3;
        run_contention(4'b1111, 5);
        run_single(1, 10, 1, 4, 10);
        run_single(1, 10, 5, 4, 0);
        run_single(2, 8, 2, 3, 0);
        run_single(3, 8, 3, 3, 0);
        run_single(1, 0, 0, 1, 0);
        run_single(0, 255, 0, 1, 0);
        run_single(2, 6, 4, 2, 0);

        for (int n = 0; n < 40; n++) begin
            i  = $urandom_range(0, NREQ - 1);
            L  = $urandom_range(0, 24);
            a  = $urandom_range(0, 5);
            t  = (L >= 2) ? $urandom_range(1, L - 1) : 1;
            L2 = $urandom_range(0, 12);
            run_single(i, L, a, t, L2);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        for (int n = 0; n < 6; n++) begin
            mask = $urandom_range(1, (1 << NREQ) - 1);
            for (int m = 0; m < NREQ; m++) lens[m] = $urandom_range(0, 6);
            k = $urandom_range(2, 6);
            run_contention(mask, k);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
